// File: rtl/shift_arbiter.sv
// -----------------------------------------------------------------------------
// shift_arbiter
//
// Shares one combinational barrel shifter between two requesters in the
// execute stage. Port 0 is the ALU shift path. Port 1 is the load/store
// byte-alignment path. A round-robin arbiter picks at most one request per
// cycle. The shifted result is registered in a single-entry output stage,
// together with the ID of the requester that owns it.
//
// Ports
//   clk         core clock; all state updates on the rising edge
//   rst_n       asynchronous active-low reset
//   reqN_valid  requester N has a shift pending (N = 0, 1)
//   reqN_ready  requester N's request is accepted this cycle
//   reqN_a      requester N operand
//   reqN_shamt  requester N shift amount
//   reqN_arith  requester N sign-fill select (ignored for left shifts)
//   reqN_right  requester N direction: 1 = right, 0 = left
//   resp_valid  result register holds a valid result
//   resp_ready  consumer takes the result this cycle
//   resp_id     requester that owns the result
//   resp_data   shifted result
// -----------------------------------------------------------------------------
module shift_arbiter #(
    parameter int XLEN = 32,
    parameter int SHW  = 5
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [XLEN-1:0] req0_a,
    input  logic [SHW-1:0]  req0_shamt,
    input  logic            req0_arith,
    input  logic            req0_right,

    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [XLEN-1:0] req1_a,
    input  logic [SHW-1:0]  req1_shamt,
    input  logic            req1_arith,
    input  logic            req1_right,

    output logic            resp_valid,
    input  logic            resp_ready,
    output logic            resp_id,
    output logic [XLEN-1:0] resp_data
);

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
    logic free;
    logic prio;
    logic grant0;
    logic grant1;
    logic grant_any;

    // The output stage can take a new result when it is empty or is being
    // drained in the same cycle.
    assign free = ~resp_valid | resp_ready;

    // Requester 1 wins a tie only when the pointer favours it. When just one
    // requester is valid, it wins regardless of the pointer.
    assign grant0    = free & req0_valid & (~req1_valid | ~prio);
    assign grant1    = free & req1_valid & (~req0_valid |  prio);
    assign grant_any = grant0 | grant1;

    // The flops are already held in reset, so rst_n only gates the ready
    // outputs. Requesters then never see a handshake while reset is asserted.
    assign req0_ready = grant0 & rst_n;
    assign req1_ready = grant1 & rst_n;

    // -------------------------------------------------------------------------
    // Operand mux
    // -------------------------------------------------------------------------
    logic [XLEN-1:0] sel_a;
    logic [SHW-1:0]  sel_shamt;
    logic            sel_arith;
    logic            sel_right;

    always_comb begin
        sel_a     = req0_a;
        sel_shamt = req0_shamt;
        sel_arith = req0_arith;
        sel_right = req0_right;
        if (grant1) begin
            sel_a     = req1_a;
            sel_shamt = req1_shamt;
            sel_arith = req1_arith;
            sel_right = req1_right;
        end
    end

    // -------------------------------------------------------------------------
    // Barrel shifter
    // A single right-shifting log stage chain serves both directions. A left
    // shift is done by bit-reversing the operand, shifting right with zero
    // fill, and reversing the result back.
    // -------------------------------------------------------------------------
    logic            fill;
    logic [XLEN-1:0] sh_in;
    logic [XLEN-1:0] shift_out;
    logic [XLEN-1:0] stg [SHW+1];

    assign fill = sel_right & sel_arith & sel_a[XLEN-1];

    always_comb begin
        sh_in = sel_a;
        if (!sel_right) begin
            for (int i = 0; i < XLEN; i++) begin
                sh_in[i] = sel_a[XLEN-1-i];
            end
        end
    end

    assign stg[0] = sh_in;

    for (genvar s = 0; s < SHW; s++) begin : g_stage
        localparam int DIST = 1 << s;
        assign stg[s+1] = sel_shamt[s] ? {{DIST{fill}}, stg[s][XLEN-1:DIST]}
                                       : stg[s];
    end

    always_comb begin
        shift_out = stg[SHW];
        if (!sel_right) begin
            for (int i = 0; i < XLEN; i++) begin
                shift_out[i] = stg[SHW][XLEN-1-i];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Result register and round-robin pointer
    // A grant in the same cycle as a drain overwrites the register, so
    // resp_valid stays high and back-to-back results flow at one per cycle.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            resp_data  <= '0;
            prio       <= 1'b0;
        end else if (grant_any) begin
            resp_valid <= 1'b1;
            resp_id    <= grant1;
            resp_data  <= shift_out;
            prio       <= ~grant1;
        end else if (resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
module tb_shift_arbiter;

    localparam int XLEN = 32;
    localparam int SHW  = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            req0_valid, req0_ready, req0_arith, req0_right;
    logic [XLEN-1:0] req0_a;
    logic [SHW-1:0]  req0_shamt;
    logic            req1_valid, req1_ready, req1_arith, req1_right;
    logic [XLEN-1:0] req1_a;
    logic [SHW-1:0]  req1_shamt;
    logic            resp_valid, resp_ready, resp_id;
    logic [XLEN-1:0] resp_data;

    always #5 clk = ~clk;

    shift_arbiter #(.XLEN(XLEN), .SHW(SHW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_shamt (req0_shamt),
        .req0_arith (req0_arith),
        .req0_right (req0_right),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_shamt (req1_shamt),
        .req1_arith (req1_arith),
        .req1_right (req1_right),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_data  (resp_data)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic            id;
        logic [XLEN-1:0] data;
    } resp_t;

    resp_t sb[$];

    // Reference model state: is a result held, and who wins the next tie.
    bit m_valid;
    int m_next;
    int m_winner;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [XLEN-1:0] ref_shift(input logic [XLEN-1:0] a, input int sh,
                                                  input bit arith, input bit right);
        if (!right) return a << sh;
        if (arith)  return XLEN'($signed(a) >>> sh);
        return a >> sh;
    endfunction

    // Monitor and scoreboard: samples on the falling edge, between updates.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_resp_valid", resp_valid, 0);
            check("rst_resp_data", resp_data, 0);
            check("rst_resp_id", resp_id, 0);
            check("rst_req0_ready", req0_ready, 0);
            check("rst_req1_ready", req1_ready, 0);
            sb.delete();
            m_valid = 0;
            m_next  = 0;
        end else begin
            check("resp_valid", resp_valid, m_valid);
            if (resp_valid) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_empty: resp_valid=1 with no expected result at t=%0t", $time);
                end else begin
                    check("resp_id", resp_id, sb[0].id);
                    check("resp_data", resp_data, sb[0].data);
                    if (resp_ready) void'(sb.pop_front());
                end
            end
            m_winner = -1;
            if (!m_valid || resp_ready) begin
                if (req0_valid && req1_valid) m_winner = m_next;
                else if (req0_valid)          m_winner = 0;
                else if (req1_valid)          m_winner = 1;
            end
            check("req0_ready", req0_ready, (m_winner == 0) ? 1 : 0);
            check("req1_ready", req1_ready, (m_winner == 1) ? 1 : 0);
            if (m_winner == 0) begin
                sb.push_back('{1'b0, ref_shift(req0_a, int'(req0_shamt), req0_arith, req0_right)});
                m_next  = 1;
                m_valid = 1;
            end else if (m_winner == 1) begin
                sb.push_back('{1'b1, ref_shift(req1_a, int'(req1_shamt), req1_arith, req1_right)});
                m_next  = 0;
                m_valid = 1;
            end else if (resp_ready) begin
                m_valid = 0;
            end
        end
    end

    task automatic drive(input bit port, input logic [31:0] a, input logic [4:0] sh,
                         input bit ar, input bit rt);
        if (port) begin
            req1_valid = 1; req1_a = a; req1_shamt = sh; req1_arith = ar; req1_right = rt;
        end else begin
            req0_valid = 1; req0_a = a; req0_shamt = sh; req0_arith = ar; req0_right = rt;
        end
    endtask

    // Single uncontended request with resp_ready=1 and the output stage empty.
    task automatic run_one(input bit port, input logic [31:0] a, input logic [4:0] sh,
                           input bit ar, input bit rt, input logic [31:0] exp, input string name);
        @(posedge clk); #1;
        drive(port, a, sh, ar, rt);
        @(negedge clk);
        check({name, "_ready"}, port ? req1_ready : req0_ready, 1);
        @(posedge clk); #1;
        req0_valid = 0;
        req1_valid = 0;
        @(negedge clk);
        check({name, "_valid"}, resp_valid, 1);
        check({name, "_id"}, resp_id, {31'b0, port});
        check({name, "_data"}, resp_data, exp);
    endtask

    task automatic rand_fields(input bit port);
        logic [4:0] sh;
        case ($urandom_range(0, 5))
            0:       sh = 5'd0;
            1:       sh = 5'd31;
            default: sh = 5'($urandom_range(0, 31));
        endcase
        drive(port, $urandom, sh, 1'($urandom), 1'($urandom));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc0, acc1;
        rst_n = 0;
        req0_valid = 0; req0_a = 0; req0_shamt = 0; req0_arith = 0; req0_right = 0;
        req1_valid = 0; req1_a = 0; req1_shamt = 0; req1_arith = 0; req1_right = 0;
        resp_ready = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;

        // Directed shift modes, one request at a time.
        resp_ready = 1;
        run_one(0, 32'h0000_0116, 5'd3,  0, 1, 32'h0000_0022, "srl3");
        run_one(1, 32'h8000_0000, 5'd4,  1, 1, 32'hF800_0000, "sra4");
        run_one(1, 32'h8000_0000, 5'd4,  0, 1, 32'h0800_0000, "srl4");
        run_one(0, 32'h0000_0001, 5'd31, 0, 0, 32'h8000_0000, "sll31");
        run_one(1, 32'hDEAD_BEEF, 5'd0,  1, 1, 32'hDEAD_BEEF, "sh0");
        run_one(0, 32'h8765_4321, 5'd8,  1, 0, 32'h6543_2100, "sll_arith_ignored");

        // Contention from reset: grants alternate 0,1,0,1 with ids lagging by one.
        @(posedge clk); #1 rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        rand_fields(0);
        rand_fields(1);
        rst_n = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("alt_grant", {30'b0, req1_ready, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd2);
            if (i > 0) check("alt_id", resp_id, (i - 1) % 2);
            acc0 = req0_ready;
            acc1 = req1_ready;
            @(posedge clk); #1;
            if (acc0) rand_fields(0);
            if (acc1) rand_fields(1);
        end
        req0_valid = 0;
        req1_valid = 0;
        repeat (3) @(posedge clk);

        // Backpressure: frozen result, then same-cycle drain and accept.
        #1;
        resp_ready = 0;
        drive(0, 32'h1234_5678, 5'd8, 0, 0);
        @(negedge clk);
        check("bp_accept0", req0_ready, 1);
        @(posedge clk); #1;
        req0_valid = 0;
        drive(1, 32'hF000_000F, 5'd4, 1, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_valid", resp_valid, 1);
            check("bp_frozen_data", resp_data, 32'h3456_7800);
            check("bp_frozen_id", resp_id, 0);
            check("bp_readys", {30'b0, req1_ready, req0_ready}, 0);
            @(posedge clk); #1;
        end
        resp_ready = 1;
        @(negedge clk);
        check("bp_accept1", req1_ready, 1);
        @(posedge clk); #1;
        req1_valid = 0;
        @(negedge clk);
        check("bp_new_valid", resp_valid, 1);
        check("bp_new_id", resp_id, 1);
        check("bp_new_data", resp_data, 32'hFF00_0000);
        @(posedge clk); #1;

        // Asynchronous reset while a result is held.
        resp_ready = 0;
        drive(0, 32'hA5A5_0000, 5'd1, 0, 1);
        @(posedge clk); #1;
        drive(0, 32'h0000_00F0, 5'd4, 0, 1);
        drive(1, 32'h0000_0F00, 5'd8, 0, 1);
        @(negedge clk);
        check("ar_pre_valid", resp_valid, 1);
        check("ar_pre_data", resp_data, 32'h52D2_8000);
        #2 rst_n = 0;
        #1;
        check("ar_valid_now", resp_valid, 0);
        check("ar_data_now", resp_data, 0);
        check("ar_ready0_now", req0_ready, 0);
        check("ar_ready1_now", req1_ready, 0);
        @(posedge clk);
        @(posedge clk); #2;
        rst_n = 1;
        resp_ready = 1;
        @(negedge clk);
        check("ar_first_grant0", req0_ready, 1);
        check("ar_first_grant1", req1_ready, 0);
        @(posedge clk); #1;
        req0_valid = 0;
        @(negedge clk);
        check("ar_second_grant1", req1_ready, 1);
        @(posedge clk); #1;
        req1_valid = 0;
        repeat (2) @(posedge clk);

        // Randomized traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            acc0 = req0_valid && req0_ready;
            acc1 = req1_valid && req1_ready;
            @(posedge clk); #1;
            if (acc0) req0_valid = 0;
            if (acc1) req1_valid = 0;
            if (!req0_valid && $urandom_range(0, 99) < 60) rand_fields(0);
            if (!req1_valid && $urandom_range(0, 99) < 60) rand_fields(1);
            resp_ready = ($urandom_range(0, 99) < 70);
        end
        @(negedge clk);
        acc0 = req0_valid && req0_ready;
        acc1 = req1_valid && req1_ready;
        @(posedge clk); #1;
        if (acc0) req0_valid = 0;
        if (acc1) req1_valid = 0;
        resp_ready = 1;
        for (int i = 0; i < 10 && (req0_valid || req1_valid); i++) begin
            @(negedge clk);
            acc0 = req0_ready;
            acc1 = req1_ready;
            @(posedge clk); #1;
            if (acc0) req0_valid = 0;
            if (acc1) req1_valid = 0;
        end
        check("drain_requests", {30'b0, req1_valid, req0_valid}, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("drain_sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Shares one combinational 32-bit barrel shifter between two requesters: port 0 is the ALU shift path and port 1 is the load/store byte-alignment path.
- Uses round-robin arbitration with a valid/ready request handshake on each port.
- Registers the shifted result in a single-entry output stage with a valid/ready response handshake, tagged with the requester ID.
- Sits in the Core execute stage, between issue and writeback/LSU.

Parameters:
- XLEN, 32, data width of operand and result.
- SHW, 5, shift-amount width; equals log2(XLEN).

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 has a shift pending.
- req0_ready  output  1  requester 0's request is accepted this cycle.
- req0_a  input  XLEN  requester 0 operand.
- req0_shamt  input  SHW  requester 0 shift amount.
- req0_arith  input  1  requester 0 arithmetic (sign-fill) select.
- req0_right  input  1  requester 0 direction: 1 = right, 0 = left.
- req1_valid, req1_ready, req1_a, req1_shamt, req1_arith, req1_right  same directions and widths as the port-0 set, for requester 1.
- resp_valid  output  1  result register holds a valid result.
- resp_ready  input  1  consumer takes the result this cycle.
- resp_id  output  1  ID of the requester that owns the result.
- resp_data  output  XLEN  shifted result.

Behaviour:
- Reset (rst_n low, asynchronous):
  - resp_valid=0, resp_id=0, resp_data=0.
  - Priority pointer prio=0, so requester 0 is favoured first.
  - req0_ready=0 and req1_ready=0 while reset is held.
  - An in-flight result is discarded; there is no replay.
- Output stage free condition: free = !resp_valid | resp_ready.
- Grant logic (combinational):
  - When free and exactly one reqN_valid is high, grant that N.
  - When free and both are valid, grant N = prio.
  - When not free, no grant.
  - reqN_ready = grant to N.
  - At most one ready is high per cycle.
  - A ready is never high without the matching valid.
- Datapath: the granted request's a, shamt, arith and right are muxed onto the shifter.
  - right=1, arith=0: logical right, zero fill.
  - right=1, arith=1: arithmetic right, replicate bit XLEN-1.
  - right=0: logical left, zero fill; arith is ignored.
  - shamt=0 passes the operand through unchanged.
- Result register:
  - On a grant edge: resp_data takes the shifter output, resp_id takes N, resp_valid becomes 1.
  - With no grant and resp_ready=1: resp_valid becomes 0; resp_data and resp_id hold their values.
  - While resp_valid=1 and resp_ready=0: resp_data and resp_id are frozen.
- Latency: result visible 1 cycle after acceptance.
- Throughput: 1 result per cycle when resp_ready is held high.
- Pointer: on each grant, prio becomes !N. With no grant, prio holds.
- Simultaneous drain and accept: resp_ready=1 with a grant in the same cycle overwrites the register with the new result, and resp_valid stays 1.
- Requesters must hold a, shamt, arith, right and valid stable until ready; the block does not check this.
- Starvation bound: a continuously valid requester is granted within 2 free cycles.

Test Plan:
- Single request, no contention: req0 a=0x00000116, shamt=3, right=1, arith=0, resp_ready=1 -> req0_ready=1 in cycle 0; next cycle resp_valid=1, resp_id=0, resp_data=0x00000022.
- Shift modes: req1 a=0x80000000, shamt=4, right=1, arith=1 -> resp_data=0xF8000000, resp_id=1.
  - Same request with arith=0 -> 0x08000000.
  - a=0x00000001, shamt=31, right=0 -> 0x80000000.
  - shamt=0 -> a unchanged.
- Contention from reset with both valid continuously and resp_ready=1 -> grants alternate 0,1,0,1, and resp_id sequence is 0,1,0,1 with 1-cycle lag.
- Backpressure: result pending with resp_ready=0 for 3 cycles -> resp_data/resp_id frozen, both readys 0. Then resp_ready=1 -> same-cycle grant of the waiting request, and resp_valid stays 1 with the new data.
- Reset mid-operation: assert rst_n=0 asynchronously while resp_valid=1 -> resp_valid=0, resp_data=0 immediately, without waiting for a clock edge. After release with both valid, requester 0 is granted first.
